// File: rtl/hazard_unit.sv
// hazard_unit
// Pipeline control for a five-stage pipeline. It drives the enable and
// synchronous flush of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the
// PC write enable.
//
// Ports:
//   CLK, nRST                      clock, synchronous active-low reset
//   ihit, dhit                     instruction / data memory handshake
//   ifid_rs, ifid_rt               sources of the instruction in IF/ID
//   idex_dREN, idex_wsel           load flag and destination in ID/EX
//   exmem_dREN, exmem_dWEN         memory op in EX/MEM
//   exmem_redirect, exmem_halt     control transfer / halt in EX/MEM
//   pc_en, *_en, *_flush           pipeline register controls
//   halted                         sticky halt indication
//   stall_cnt, flush_cnt           event counters (wrap modulo 2^CNT_W)
module hazard_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_wsel,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_redirect,
    input  logic             exmem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_busy;
    logic load_use;
    logic redirect_taken;

    assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign load_use = idex_dREN & (idex_wsel != 5'd0) &
                      ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

    always_comb begin
        state_d        = state_q;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        memwb_flush    = 1'b0;
        redirect_taken = 1'b0;

        unique case (state_q)
            RUN: begin
                // Strict priority: only the first matching hazard acts.
                if (mem_busy) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                end else if (exmem_halt) begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    state_d     = DRAIN;
                end else if (exmem_redirect) begin
                    ifid_flush     = 1'b1;
                    idex_flush     = 1'b1;
                    exmem_flush    = 1'b1;
                    redirect_taken = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (!ihit) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
            DRAIN: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                state_d  = HALTED;
            end
            HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            default: state_d = RUN;
        endcase

        // Reset clears every pipeline register regardless of state.
        if (!nRST) begin
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            idex_en        = 1'b0;
            exmem_en       = 1'b0;
            memwb_en       = 1'b0;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            exmem_flush    = 1'b1;
            memwb_flush    = 1'b1;
            redirect_taken = 1'b0;
        end
    end

    always_comb begin
        halted_d    = halted_q | (state_q == DRAIN);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == RUN && !pc_en) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_taken) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= RUN;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control unit that drives the `flush`/`enable` inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves load-use hazards, instruction/data cache waits, taken-branch/jump squashes and halt drain. It also keeps stall and flush event counters for the testbench. It sits beside the datapath, consumes stage fields taken from the pipeline register outputs, and is the driving end of each register's flush/enable pair.

## Interface
- CNT_W, 32, width of the stall and flush event counters
- CLK  in  1  system clock; all state updates on rising edge
- nRST  in  1  reset; synchronous, active-low
- ihit  in  1  instruction memory returned valid data this cycle
- dhit  in  1  data memory completed the EX/MEM access this cycle
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in IF/ID
- idex_dREN  in  1  instruction in ID/EX is a load
- idex_wsel  in  5  destination register of the instruction in ID/EX
- exmem_dREN, exmem_dWEN  in  1 each  memory op in EX/MEM
- exmem_redirect  in  1  taken branch, jump, jr or jal resolved in EX/MEM
- exmem_halt  in  1  halt instruction in EX/MEM
- pc_en  out  1  PC register update enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous clear (bubble) of the register; wins over enable
- halted  out  1  sticky halt indication to the system
- stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN
- flush_cnt  out  CNT_W  cycles with exmem_redirect honoured

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Conditions evaluated each cycle in RUN:
  - mem_busy = (exmem_dREN|exmem_dWEN) & ~dhit
  - load_use = idex_dREN & idex_wsel!=0 & (idex_wsel==ifid_rs | idex_wsel==ifid_rt)
- RUN outputs, by strict priority. Defaults are all en=1 and all flush=0.
  1. mem_busy: pc_en, ifid_en, idex_en, exmem_en = 0. memwb_flush = 1 with memwb_en = 1 (bubble into WB).
  2. exmem_halt: pc_en = 0. ifid_flush, idex_flush, exmem_flush = 1. memwb_en = 1. Next state is DRAIN.
  3. exmem_redirect: pc_en = 1. ifid_flush, idex_flush, exmem_flush = 1. flush_cnt increments.
  4. load_use: pc_en = 0, ifid_en = 0, idex_flush = 1.
  5. ~ihit: pc_en = 0, ifid_flush = 1. Downstream registers advance.
- Only the winning rule applies. A load_use coincident with ~ihit is handled by rule 4.
- DRAIN (exactly one cycle, halt sits in MEM/WB for writeback): pc_en = 0, all four flush = 0, ifid/idex/exmem_en = 0, memwb_en = 0. Next state is HALTED.
- HALTED: every en = 0, every flush = 0, halted = 1. Leaves only on reset.
- stall_cnt increments in RUN whenever pc_en = 0. Counters wrap modulo 2^CNT_W.
- halted is registered: it goes to 1 on the edge that enters HALTED.

## Timing
- Hazard outputs are combinational from the inputs and the current state. State and counters are registered.
- Reset (nRST = 0 at an edge): next state RUN, halted = 0, stall_cnt = 0, flush_cnt = 0.
- While nRST = 0, outputs are forced to pc_en = 0, all en = 0, all flush = 1. This clears the pipeline even when reset is asserted mid-stall or mid-drain.
- Load-use costs exactly one bubble. On the next edge the load has moved to EX/MEM, so load_use clears unless dhit is low (then rule 1 holds everything).
- Redirect costs three squashed slots. The PC loads the target on the same edge.
- Halt to halted latency: halt in EX/MEM at cycle t, DRAIN at t+1, halted = 1 from t+2.
- A halt that arrives with mem_busy cannot occur in the same stage, because halt carries no memory op. A halt behind a busy load waits in ID/EX until dhit.
- Counter wrap: at all-ones, the next increment gives 0.

## Test plan
- Load-use: idex_dREN = 1, idex_wsel = 5, ifid_rs = 5, ihit = dhit = 1 -> pc_en = 0, ifid_en = 0, idex_flush = 1 for one cycle. Next cycle all en = 1. stall_cnt = 1. Repeat with idex_wsel = 0 -> no stall.
- Data wait: exmem_dREN = 1, dhit = 0 for 3 cycles, then 1 -> pc/ifid/idex/exmem_en = 0 and memwb_flush = 1 for 3 cycles. Normal on the 4th cycle. stall_cnt = 3.
- Redirect with load_use and ~ihit asserted together -> only the redirect response: pc_en = 1, three flushes. flush_cnt = 1, stall_cnt unchanged.
- Halt: exmem_halt = 1 at cycle 10 -> DRAIN at cycle 11, halted = 1 at cycle 12. All en = 0 afterwards despite ihit toggling.
- Reset while HALTED, and reset mid data-wait -> all flush = 1 and en = 0 during reset. Afterwards state is RUN, halted = 0, counters = 0.
- Wrap: CNT_W = 4, 17 consecutive ~ihit cycles -> stall_cnt = 1.
